// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared image geometry defaults, pixel type and line feeder state encoding
package image_pkg;

  localparam int DEF_IMG_WIDTH  = 512;
  localparam int DEF_IMG_HEIGHT = 512;
  localparam int PIXEL_W        = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_WAIT_INTR,
    ST_LINE,
    ST_PAD_WAIT,
    ST_PAD,
    ST_DONE
  } feeder_state_e;

  // Two-bit counter increment that sticks at its maximum value
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// rtl/pixel_skid_fifo.sv - two-entry pixel buffer between frame memory reads and the filter handshake
module pixel_skid_fifo
  import image_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_en_i,
  output logic [7:0] rd_data_o,
  output logic       valid_o,
  output logic [1:0] count_o
);

  pixel_t     mem0_q, mem1_q;
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       do_wr, do_rd;

  // A pop needs data; a push is dropped only when full with no pop (the feeder never does this)
  assign do_rd = rd_en_i && (count_q != 2'd0);
  assign do_wr = wr_en_i && ((count_q != 2'd2) || do_rd);

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) count_d = count_q + 2'd1;
    if (!do_wr && do_rd) count_d = count_q - 2'd1;
  end

  // Storage, pointers and occupancy; everything clears so the head reads 0 after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_wr) begin
        if (wr_ptr_q) mem1_q <= wr_data_i;
        else          mem0_q <= wr_data_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_rd) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign rd_data_o = rd_ptr_q ? mem1_q : mem0_q;
  assign valid_o   = (count_q != 2'd0);
  assign count_o   = count_q;

endmodule

// File: rtl/image_line_feeder.sv
// rtl/image_line_feeder.sv - streams a frame from memory into the line-buffer filter, gated by its line interrupt
module image_line_feeder
  import image_pkg::*;
#(
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  input  logic              i_intr,
  output logic              o_data_valid,
  output logic [7:0]        o_data,
  input  logic              i_data_ready
);

  localparam int COL_W     = $clog2(IMG_WIDTH + 1);
  localparam int LINE_W    = $clog2(IMG_HEIGHT + 1);
  localparam int PAD_W     = $clog2(PAD_LINES + 2);
  localparam int PRIME_EFF = (IMG_HEIGHT <= PRIME_LINES) ? IMG_HEIGHT : PRIME_LINES;

  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] LAST_PRIME = LINE_W'(PRIME_EFF - 1);
  localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [PAD_W-1:0]  LAST_PAD   = PAD_W'(PAD_LINES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);

  // Where the frame goes once its last real line has been issued
  localparam feeder_state_e AFTER_FRAME = (PAD_LINES > 0) ? ST_PAD_WAIT : ST_DONE;

  feeder_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [PAD_W-1:0]  pad_q, pad_d;
  logic [1:0]        pend_q, pend_d;
  logic              intr_q, intr_prev_q;
  logic              infl_q, infl_zero_q;

  logic       edge_w, take, pop, space, issue, issue_zero, line_end;
  logic [2:0] occ;
  logic [1:0] fifo_count;
  logic [7:0] push_data;

  assign edge_w = intr_q && !intr_prev_q;
  assign pop    = o_data_valid && i_data_ready;

  // Entries held plus the one possibly still on its way must leave room for a new issue
  assign occ   = {1'b0, fifo_count} + {2'b00, infl_q} - {2'b00, pop};
  assign space = (occ < 3'd2);

  // A fresh edge may be spent in the same cycle it is seen, saving a cycle of line latency
  assign take = ((state_q == ST_WAIT_INTR) || (state_q == ST_PAD_WAIT)) &&
                ((pend_q != 2'd0) || edge_w);

  assign line_end = issue && (col_q == LAST_COL);

  // State register
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (i_start) state_d = ST_PRIME;
      ST_PRIME:     if (line_end && (line_q == LAST_PRIME))
                      state_d = (IMG_HEIGHT <= PRIME_LINES) ? AFTER_FRAME : ST_WAIT_INTR;
      ST_WAIT_INTR: if (take) state_d = ST_LINE;
      ST_LINE:      if (line_end) state_d = (line_q == LAST_LINE) ? AFTER_FRAME : ST_WAIT_INTR;
      ST_PAD_WAIT:  if (take) state_d = ST_PAD;
      ST_PAD:       if (line_end) state_d = (pad_q == LAST_PAD) ? ST_DONE : ST_PAD_WAIT;
      ST_DONE:      if (o_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Per-state outputs: issue strobes, done pulse and busy flag
  always_comb begin
    issue       = 1'b0;
    issue_zero  = 1'b0;
    o_done      = 1'b0;
    case (state_q)
      ST_PRIME, ST_LINE: issue = space;
      ST_PAD: begin
        issue      = space;
        issue_zero = 1'b1;
      end
      ST_DONE: o_done = (fifo_count == 2'd0) && !infl_q;
      default: ;
    endcase
    o_mem_rd_en = issue && !issue_zero;
    o_busy      = (state_q != ST_IDLE) && !o_done;
  end

  // Address, column, line and pad counters advance on every issued pixel
  always_comb begin
    addr_d = addr_q;
    col_d  = col_q;
    line_d = line_q;
    pad_d  = pad_q;
    if ((state_q == ST_IDLE) && i_start) begin
      addr_d = '0;
      col_d  = '0;
      line_d = '0;
      pad_d  = '0;
    end else if (issue) begin
      if (!issue_zero && (addr_q != LAST_ADDR)) addr_d = addr_q + ADDR_W'(1);
      col_d = line_end ? '0 : col_q + COL_W'(1);
      if (line_end && issue_zero)  pad_d  = pad_q + PAD_W'(1);
      if (line_end && !issue_zero) line_d = line_q + LINE_W'(1);
    end
  end

  // Interrupt credit: +1 per edge, -1 per line taken, sticks at 3, forced to 0 while idle
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_IDLE)     pend_d = 2'd0;
    else if (edge_w && !take)   pend_d = sat_inc2(pend_q);
    else if (!edge_w && take)   pend_d = pend_q - 2'd1;
  end

  // Counter, interrupt and read-pipeline registers
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      addr_q      <= '0;
      col_q       <= '0;
      line_q      <= '0;
      pad_q       <= '0;
      pend_q      <= 2'd0;
      intr_q      <= 1'b0;
      intr_prev_q <= 1'b0;
      infl_q      <= 1'b0;
      infl_zero_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      col_q       <= col_d;
      line_q      <= line_d;
      pad_q       <= pad_d;
      pend_q      <= pend_d;
      intr_q      <= i_intr;
      intr_prev_q <= intr_q;
      infl_q      <= issue;
      infl_zero_q <= issue_zero;
    end
  end

  assign o_mem_addr = addr_q;
  assign push_data  = infl_zero_q ? 8'd0 : i_mem_data;

  pixel_skid_fifo u_fifo (
    .clk_i     (axi_clk),
    .rst_ni    (axi_reset_n),
    .wr_en_i   (infl_q),
    .wr_data_i (push_data),
    .rd_en_i   (i_data_ready),
    .rd_data_o (o_data),
    .valid_o   (o_data_valid),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_image_line_feeder.sv
// tb/tb_image_line_feeder.sv - self-checking bench for image_line_feeder on an 8x6 frame
module tb_image_line_feeder;

  localparam int W      = 8;
  localparam int H      = 6;
  localparam int PRIME  = 4;
  localparam int PAD    = 2;
  localparam int AW     = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          o_busy, o_done, o_mem_rd_en;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    mem_data = 8'd0;
  logic          i_intr = 1'b0;
  logic          o_data_valid;
  logic [7:0]    o_data;
  logic          i_data_ready = 1'b1;

  int   n_pass = 0;
  int   n_total = 0;
  int   got_q[$];
  int   model_q[$];
  int   done_cnt = 0;
  bit   rand_ready = 1'b0;
  bit   stall_seen = 1'b0;
  logic [7:0] held_data = 8'd0;

  typedef struct {
    bit do_start;
    int n_intr;
    int exp_total;
    bit exp_busy;
    int exp_done;
  } step_t;

  step_t steps[5];

  image_line_feeder #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(PRIME), .PAD_LINES(PAD), .ADDR_W(AW)
  ) dut (
    .axi_clk      (clk),
    .axi_reset_n  (rst_n),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_mem_rd_en  (o_mem_rd_en),
    .o_mem_addr   (o_mem_addr),
    .i_mem_data   (mem_data),
    .i_intr       (i_intr),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .i_data_ready (i_data_ready)
  );

  always #5 clk = ~clk;

  // Frame memory holds data = addr, one-cycle read latency
  always @(posedge clk) if (o_mem_rd_en) mem_data <= {2'b00, o_mem_addr};

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Ready source: fixed high or a fair coin each cycle
  initial forever begin
    @(posedge clk);
    #1 i_data_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Handshake monitor, stall-hold check and done counter
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("hold_valid", int'(o_data_valid), 1);
        check("hold_data", int'(o_data), int'(held_data));
      end
      if (o_data_valid && i_data_ready) got_q.push_back(int'(o_data));
      stall_seen = o_data_valid && !i_data_ready;
      held_data  = o_data;
      if (o_done) done_cnt++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic pulse_intr();
    @(posedge clk); #1 i_intr = 1'b1;
    @(posedge clk); #1 i_intr = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget);
    int c = 0;
    while (got_q.size() < target && c < budget) begin
      @(posedge clk);
      c++;
    end
  endtask

  task automatic compare_seq(input string name, input int n);
    int mism = 0;
    check({name, "_len"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      if (got_q[i] != model_q[i]) mism++;
    check({name, "_data_mismatches"}, mism, 0);
  endtask

  task automatic run_table(input bit rnd, input string tag);
    int last;
    rand_ready = rnd;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      if (steps[s].do_start) pulse_start();
      for (int k = 0; k < steps[s].n_intr; k++) begin
        pulse_intr();
        repeat (20) @(posedge clk);
      end
      wait_count(steps[s].exp_total, 600);
      repeat (30) @(posedge clk);
      last = (got_q.size() > 0) ? got_q[$] : -1;
      check($sformatf("%s_step%0d_total", tag, s), got_q.size(), steps[s].exp_total);
      check($sformatf("%s_step%0d_last", tag, s), last, model_q[steps[s].exp_total-1]);
      check($sformatf("%s_step%0d_busy", tag, s), int'(o_busy), int'(steps[s].exp_busy));
      check($sformatf("%s_step%0d_done", tag, s), done_cnt, steps[s].exp_done);
    end
    compare_seq({tag, "_frame"}, W*H + PAD*W);
    rand_ready = 1'b0;
  endtask

  initial begin
    // Reference stream: the frame in raster order, then the zero pad lines
    for (int i = 0; i < W*H; i++) model_q.push_back(i % 256);
    for (int i = 0; i < PAD*W; i++) model_q.push_back(0);

    // Start with no interrupts stops after the prime lines; one interrupt per further line.
    // The start in step 2 arrives while busy and must change nothing.
    steps[0] = '{do_start: 1'b1, n_intr: 0, exp_total: PRIME*W,     exp_busy: 1'b1, exp_done: 0};
    steps[1] = '{do_start: 1'b0, n_intr: 1, exp_total: (PRIME+1)*W, exp_busy: 1'b1, exp_done: 0};
    steps[2] = '{do_start: 1'b1, n_intr: 1, exp_total: H*W,         exp_busy: 1'b1, exp_done: 0};
    steps[3] = '{do_start: 1'b0, n_intr: 1, exp_total: (H+1)*W,     exp_busy: 1'b1, exp_done: 0};
    steps[4] = '{do_start: 1'b0, n_intr: 1, exp_total: (H+PAD)*W,   exp_busy: 1'b0, exp_done: 1};

    // Reset values
    #3;
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_rd_en", int'(o_mem_rd_en), 0);
    check("rst_addr", int'(o_mem_addr), 0);
    check("rst_valid", int'(o_data_valid), 0);
    check("rst_data", int'(o_data), 0);

    // Start latency: read at addr 0 right after the start edge, first pixel two edges later
    do_reset();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    check("lat_rd_en", int'(o_mem_rd_en), 1);
    check("lat_addr0", int'(o_mem_addr), 0);
    check("lat_busy", int'(o_busy), 1);
    check("lat_valid_n1", int'(o_data_valid), 0);
    @(posedge clk); #1;
    check("lat_addr1", int'(o_mem_addr), 1);
    check("lat_valid_n2", int'(o_data_valid), 0);
    @(posedge clk); #1;
    check("lat_valid_n3", int'(o_data_valid), 1);
    check("lat_data_n3", int'(o_data), 0);

    run_table(1'b0, "rdy1");
    run_table(1'b1, "rdyrnd");

    // Four back-to-back interrupt edges during PRIME: credit sticks at 3
    do_reset();
    pulse_start();
    repeat (3) @(posedge clk);
    for (int k = 0; k < 4; k++) pulse_intr();
    wait_count((H+1)*W, 600);
    repeat (50) @(posedge clk);
    check("sat_total", got_q.size(), (H+1)*W);
    check("sat_busy", int'(o_busy), 1);
    check("sat_done", done_cnt, 0);
    pulse_intr();
    wait_count((H+PAD)*W, 600);
    repeat (30) @(posedge clk);
    check("sat_done_after", done_cnt, 1);
    compare_seq("sat_frame", (H+PAD)*W);

    // Asynchronous reset at pixel 20 of PRIME, then restart from address 0
    do_reset();
    pulse_start();
    wait_count(20, 300);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(o_busy), 0);
    check("mid_rst_rd_en", int'(o_mem_rd_en), 0);
    check("mid_rst_addr", int'(o_mem_addr), 0);
    check("mid_rst_valid", int'(o_data_valid), 0);
    check("mid_rst_data", int'(o_data), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    got_q.delete();
    // Interrupts while idle are discarded
    pulse_intr();
    repeat (2) @(posedge clk);
    pulse_intr();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    check("restart_addr0", int'(o_mem_addr), 0);
    check("restart_rd_en", int'(o_mem_rd_en), 1);
    wait_count(PRIME*W, 300);
    repeat (30) @(posedge clk);
    compare_seq("restart_prime", PRIME*W);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
